// File: rtl/fifo2axi_sram_oq.sv
`default_nettype none
// ============================================================================
//  Module   : fifo2axi_sram_oq
//  Purpose  : Read side of the SRAM output queue. Pops memory words (one
//             header word carrying tuser, then 128-bit half-beats) and
//             rebuilds 256-bit AXI4-Stream beats through a one-entry output
//             register.
//  Ports    : clk, reset (async, active-low)
//             din/din_valid/din_rd      : memory-word FIFO read interface
//             tdata/tstrb/tuser/tlast/tvalid/tready : AXIS master
//             proto_err                 : sticky protocol-error flag
//             pkt_count/err_count       : statistics (FIFO2AXI_STATS_EN)
//  Options  : define FIFO2AXI_STATS_EN to build the packet/error counters;
//             otherwise both counter outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo2axi_sram_oq #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128,
    parameter int DIN_W  = 202,
    parameter int HALF_W = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIN_W-1:0]    din,
    input  logic                din_valid,
    output logic                din_rd,
    output logic [DATA_W-1:0]   tdata,
    output logic [DATA_W/8-1:0] tstrb,
    output logic [USER_W-1:0]   tuser,
    output logic                tlast,
    output logic                tvalid,
    input  logic                tready,
    output logic                proto_err,
    output logic [31:0]         pkt_count,
    output logic [15:0]         err_count
);

    localparam int c_STRB_W   = HALF_W / 8;
    localparam int c_STRB_LSB = HALF_W;
    localparam int c_LAST_BIT = HALF_W + c_STRB_W;
    localparam int c_HDR_BIT  = c_LAST_BIT + 1;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_LO  = 2'd1,
        S_HI  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [USER_W-1:0]     r_tuser;
    logic [HALF_W-1:0]     r_lo_data;
    logic [c_STRB_W-1:0]   r_lo_strb;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_W-1:0]     r_tdata;
    logic [DATA_W/8-1:0]   r_tstrb;
    logic [USER_W-1:0]     r_tuser_out;
    logic                  r_proto_err;

    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_err;
    logic                  w_tuser_ld;
    logic                  w_lo_ld;
    logic [DATA_W-1:0]     w_out_data;
    logic [DATA_W/8-1:0]   w_out_strb;
    logic                  w_out_last;

    logic [HALF_W-1:0]     w_payload;
    logic [c_STRB_W-1:0]   w_strb;
    logic                  w_last;
    logic                  w_hdr;
    logic                  w_unused;

    assign w_payload = din[HALF_W-1:0];
    assign w_strb    = din[c_STRB_LSB +: c_STRB_W];
    assign w_last    = din[c_LAST_BIT];
    assign w_hdr     = din[c_HDR_BIT];
    assign w_unused  = ^din[DIN_W-1:c_HDR_BIT+1];

    assign w_out_free = ~r_tvalid | tready;
    // Pop strobe is also forced low while reset is held.
    assign din_rd     = din_valid & w_accept & reset;
    assign w_pop      = din_rd;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_tuser_ld  = 1'b0;
        w_lo_ld     = 1'b0;
        w_out_data  = '0;
        w_out_strb  = '0;
        w_out_last  = 1'b0;

        // Only words that may complete a beat need room in the output register.
        case (r_state)
            S_HDR:   w_accept = 1'b1;
            S_LO:    w_accept = w_last ? w_out_free : 1'b1;
            S_HI:    w_accept = w_out_free;
            default: w_accept = 1'b0;
        endcase

        if (w_pop) begin
            case (r_state)
                S_HDR: begin
                    if (w_hdr) begin
                        w_tuser_ld  = 1'b1;
                        w_state_nxt = S_LO;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_LO: begin
                    if (w_hdr) begin
                        w_err       = 1'b1;
                        w_tuser_ld  = 1'b1;
                        w_state_nxt = S_LO;
                    end else if (!w_last) begin
                        w_lo_ld     = 1'b1;
                        w_state_nxt = S_HI;
                    end else begin
                        // Odd-length tail: lone low half, upper half zeroed.
                        w_load      = 1'b1;
                        w_out_data  = {{HALF_W{1'b0}}, w_payload};
                        w_out_strb  = {{c_STRB_W{1'b0}}, w_strb};
                        w_out_last  = 1'b1;
                        w_state_nxt = S_HDR;
                    end
                end
                S_HI: begin
                    if (w_hdr) begin
                        // Unexpected header: pending low half is dropped.
                        w_err       = 1'b1;
                        w_tuser_ld  = 1'b1;
                        w_state_nxt = S_LO;
                    end else begin
                        w_load      = 1'b1;
                        w_out_data  = {w_payload, r_lo_data};
                        w_out_strb  = {w_strb, r_lo_strb};
                        w_out_last  = w_last;
                        w_state_nxt = w_last ? S_HDR : S_LO;
                    end
                end
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_HDR;
            r_tuser     <= '0;
            r_lo_data   <= '0;
            r_lo_strb   <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_tstrb     <= '0;
            r_tuser_out <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_tuser_ld) begin
                r_tuser <= din[USER_W-1:0];
            end
            if (w_lo_ld) begin
                r_lo_data <= w_payload;
                r_lo_strb <= w_strb;
            end
            // A load in the handshake cycle replaces the old beat with no bubble.
            if (w_load) begin
                r_tvalid    <= 1'b1;
                r_tdata     <= w_out_data;
                r_tstrb     <= w_out_strb;
                r_tlast     <= w_out_last;
                r_tuser_out <= r_tuser;
            end else if (tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign tvalid    = r_tvalid;
    assign tlast     = r_tlast;
    assign tdata     = r_tdata;
    assign tstrb     = r_tstrb;
    assign tuser     = r_tuser_out;
    assign proto_err = r_proto_err;

`ifdef FIFO2AXI_STATS_EN
    logic [31:0] r_pkt_count;
    logic [15:0] r_err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else begin
            if (r_tvalid && tready && r_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif

endmodule
`default_nettype wire
